shift_unit: RTL and testbench

SHIFT_UNIT -- requirements
Module: shift_unit

---
 rtl/shift_unit.sv | 191 +++++++++++++++++++
 tb/tb_shift_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
//
// Multi-cycle barrel-free shifter. A request (base, power, mode) is captured
// in IDLE. The working value is then shifted by up to STEP bits per cycle until
// the effective amount min(power, WIDTH) is used up. The result is held in DONE
// until the consumer takes it.
//
// Modes: 00 LSL, 01 LSR, 10 ASR, 11 SAT (signed saturating left shift).
//
// Ports
//   clk        in   clock; all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   base / power / mode are valid
//   in_ready   out  block is idle and can accept a request
//   base       in   [WIDTH-1:0] operand
//   power      in   [SHW-1:0]   unsigned shift amount
//   mode       in   [1:0]       operation select
//   out_valid  out  result / ovf are valid
//   out_ready  in   consumer accepts the result
//   result     out  [WIDTH-1:0] shifted value
//   ovf        out  saturation occurred (SAT mode only)
// -----------------------------------------------------------------------------
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] base,
    input  logic [SHW-1:0]   power,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    // Width that can hold any effective amount 0..WIDTH.
    localparam int RW = $clog2(WIDTH + 1);
    // Common width for comparing power against WIDTH without truncating either.
    localparam int CW = ((SHW > RW) ? SHW : RW) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_SAT = 2'b11
    } mode_e;

    state_e           state_q,  state_d;
    mode_e            mode_q,   mode_d;
    logic [WIDTH-1:0] work_q,   work_d;
    logic [RW-1:0]    rem_q,    rem_d;
    logic             sign_q,   sign_d;
    logic             sat_q,    sat_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q,    ovf_d;

    // Effective amount E = min(power, WIDTH).
    logic [CW-1:0] power_ext;
    logic [RW-1:0] eff_amt;

    // Bits shifted this cycle = min(STEP, remaining).
    logic [RW-1:0] step_amt;

    logic [WIDTH-1:0]        shl_val;
    logic signed [WIDTH-1:0] shl_back;
    logic signed [WIDTH-1:0] asr_val;
    logic                    sat_lossy;
    logic [WIDTH-1:0]        sat_value;

    always_comb begin
        power_ext = CW'(power);
        eff_amt   = (power_ext >= CW'(WIDTH)) ? RW'(WIDTH) : RW'(power);
        step_amt  = (rem_q < RW'(STEP)) ? rem_q : RW'(STEP);

        shl_val   = work_q << step_amt;
        asr_val   = $signed(work_q) >>> step_amt;
        // A left shift is exact iff shifting back arithmetically restores the
        // value; any lost significant bit (or sign change) means overflow.
        shl_back  = $signed(shl_val) >>> step_amt;
        sat_lossy = (shl_back != $signed(work_q));

        // Saturation limit follows the sign of the originally captured base.
        sat_value = sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // Next-state and datapath.
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        work_d   = work_q;
        rem_d    = rem_q;
        sign_d   = sign_q;
        sat_d    = sat_q;
        result_d = result_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d = mode_e'(mode);
                    work_d = base;
                    sign_d = base[WIDTH-1];
                    sat_d  = 1'b0;
                    rem_d  = eff_amt;
                    if (eff_amt == '0) begin
                        // Nothing to shift: base is already the answer.
                        state_d  = DONE;
                        result_d = base;
                        ovf_d    = 1'b0;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                rem_d = rem_q - step_amt;
                case (mode_q)
                    MODE_LSL: work_d = shl_val;
                    MODE_LSR: work_d = work_q >> step_amt;
                    MODE_ASR: work_d = asr_val;
                    MODE_SAT: begin
                        work_d = shl_val;
                        // Sticky: once any step overflows, the final value
                        // is saturated regardless of later steps.
                        sat_d  = sat_q | sat_lossy;
                    end
                    default: work_d = work_q;
                endcase

                if (rem_d == '0) begin
                    state_d  = DONE;
                    ovf_d    = (mode_q == MODE_SAT) && sat_d;
                    result_d = ((mode_q == MODE_SAT) && sat_d) ? sat_value : work_d;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= MODE_LSL;
            work_q   <= '0;
            rem_q    <= '0;
            sign_q   <= 1'b0;
            sat_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            sign_q   <= sign_d;
            sat_q    <= sat_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_unit
//
// Self-checking bench for shift_unit (WIDTH=32, SHW=32, STEP=4). Expected
// values come from an arithmetic reference model using 64-bit integers.
// -----------------------------------------------------------------------------
module tb_shift_unit;

    localparam int WIDTH = 32;
    localparam int SHW   = 32;
    localparam int STEP  = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] base;
    logic [SHW-1:0]   power;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             ovf;

    int n_vectors = 0;
    int n_errors  = 0;

    shift_unit #(
        .WIDTH (WIDTH),
        .SHW   (SHW),
        .STEP  (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .base      (base),
        .power     (power),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact arithmetic on the clamped amount.
    function automatic void ref_model(input logic [31:0] b, input logic [31:0] p,
                                      input logic [1:0] m, output logic [31:0] r,
                                      output logic o, output int lat);
        int      e;
        longint  sb;
        longint  exact;
        e   = (p >= 32) ? 32 : int'(p);
        lat = (e + STEP - 1) / STEP + 1;
        sb  = longint'($signed(b));
        o   = 1'b0;
        case (m)
            2'b00: r = 32'((64'(b)) << e);
            2'b01: r = 32'((64'(b)) >> e);
            2'b10: r = 32'(sb >>> e);
            default: begin
                exact = sb * (64'sd1 <<< e);
                o = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
                if (o) r = b[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                else   r = 32'(exact);
            end
        endcase
    endfunction

    task automatic scramble_inputs();
        in_valid = 1'b1;
        base     = $urandom;
        power    = $urandom;
        mode     = 2'($urandom_range(0, 3));
    endtask

    // Issue one request, wait for the result, hold DONE for 'hold' cycles
    // while driving junk requests, then hand the result off. Called with clk low.
    task automatic run_op(input logic [31:0] b, input logic [31:0] p, input logic [1:0] m,
                          input int hold, output logic [31:0] r, output logic o,
                          output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_req", in_ready, 1'b1);
        base = b; power = p; mode = m; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        scramble_inputs();
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            scramble_inputs();
        end
        r = result;
        o = ovf;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            scramble_inputs();
            check("done_result_stable", result, r);
            check("done_in_ready_low", in_ready, 1'b0);
        end
        // in_valid stays high on the handshake edge: it must not be accepted.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("idle_after_handshake", in_ready, 1'b1);
        check("no_valid_after_handshake", out_valid, 1'b0);
    endtask

    task automatic run_and_check(input string tag, input logic [31:0] b, input logic [31:0] p,
                                 input logic [1:0] m, input int hold);
        logic [31:0] r, er;
        logic        o, eo;
        int          lat, elat;
        ref_model(b, p, m, er, eo, elat);
        run_op(b, p, m, hold, r, o, lat);
        if (r !== er || o !== eo || lat != elat)
            $display("  op %s base=%08h power=%0d mode=%0d", tag, b, p, m);
        check({tag, "_result"}, r, er);
        check({tag, "_ovf"}, o, eo);
        check({tag, "_latency"}, lat, elat);
    endtask

    initial begin
        logic [31:0] r, b, p;
        logic        o;
        int          lat, hi_count;

        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        base = 32'h1234_5678; power = 32'd3; mode = 2'b00;

        // Reset with in_valid high: request must be ignored.
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_idle", in_ready, 1'b1);

        // Directed scenarios.
        run_op(32'h0000_0001, 32'd5, 2'b00, 0, r, o, lat);
        check("lsl5_result", r, 32'h0000_0020);
        check("lsl5_ovf", o, 1'b0);
        check("lsl5_latency", lat, 3);

        run_op(32'h8000_0000, 32'd40, 2'b10, 0, r, o, lat);
        check("asr40_result", r, 32'hFFFF_FFFF);
        check("asr40_latency", lat, 9);

        run_op(32'h4000_0000, 32'd1, 2'b11, 0, r, o, lat);
        check("sat_pos_result", r, 32'h7FFF_FFFF);
        check("sat_pos_ovf", o, 1'b1);
        run_op(32'hC000_0000, 32'd1, 2'b11, 0, r, o, lat);
        check("sat_neg_result", r, 32'h8000_0000);
        check("sat_neg_ovf", o, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd31, 2'b11, 0, r, o, lat);
        check("sat_m1_result", r, 32'h8000_0000);
        check("sat_m1_ovf", o, 1'b0);

        run_op(32'hDEAD_BEEF, 32'd0, 2'b01, 0, r, o, lat);
        check("lsr0_result", r, 32'hDEAD_BEEF);
        check("lsr0_latency", lat, 1);

        // Long DONE hold with junk requests driven.
        run_op(32'h0000_00F0, 32'd4, 2'b01, 5, r, o, lat);
        check("hold_result", r, 32'h0000_000F);

        // Boundary amounts through the model.
        run_and_check("sat_zero", 32'h0, 32'hFFFF_FFFF, 2'b11, 1);
        run_and_check("lsl_w", 32'hFFFF_FFFF, 32'd32, 2'b00, 0);
        run_and_check("asr_pos_big", 32'h7FFF_FFFF, 32'h8000_0000, 2'b10, 0);
        run_and_check("sat_neg_big", 32'h8000_0000, 32'd100, 2'b11, 0);

        // Reset in the 2nd SHIFT cycle of LSL power=20.
        base = 32'h0000_0003; power = 32'd20; mode = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_result", result, 32'h0);
        rst = 1'b0; in_valid = 1'b0;
        hi_count = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) hi_count++;
        end
        check("midrst_no_out_valid", hi_count, 0);
        run_and_check("after_rst", 32'h0000_0003, 32'd20, 2'b00, 0);

        // Randomized operations.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 15));
                1: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: p = 32'($urandom_range(0, 8));
                1: p = 32'($urandom_range(0, 33));
                2: p = 32'($urandom_range(30, 34));
                default: p = $urandom;
            endcase
            run_and_check("rand", b, p, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errors);
        $finish;
    end

endmodule
